// File: rtl/mem_ctrl_pkg.sv
// Shared constants and FSM encoding for the RAM access sequencer.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t RD_REQ = 3'd1;
  localparam state_t RD_CAP = 3'd2;
  localparam state_t WR_REQ = 3'd3;
  localparam state_t DONE   = 3'd4;

endpackage

// File: rtl/mem_ctrl.sv
// MAR/MDR holder and single-word RAM access sequencer: read takes 3 cycles, write 2, then IDLE.
// Requests and register loads are honoured only in IDLE; everything else is ignored while busy.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              mem_read_req,
  input  logic              mem_write_req,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata
);

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;

  // Upper bus bits never reach the MAR; addresses wrap modulo the RAM depth.
  logic unused_bus_bits;
  assign unused_bus_bits = ^bus_in[DATA_W-1:ADDR_W];

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      mar   <= '0;
      mdr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mar_in) mar <= bus_in[ADDR_W-1:0];
          if (mdr_in) mdr <= bus_in;
          if (mem_read_req)       state <= RD_REQ;
          else if (mem_write_req) state <= WR_REQ;
        end
        RD_REQ: state <= RD_CAP;
        RD_CAP: begin
          mdr   <= ram_rdata;
          state <= DONE;
        end
        WR_REQ:  state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_read  = (state == RD_REQ);
  assign ram_write = (state == WR_REQ);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign mar_out   = mar;
  assign mdr_out   = mdr;
  assign ram_addr  = mar;
  assign ram_wdata = mdr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed integration bench: mem_ctrl wired to a behavioural 512x32 synchronous RAM.
module tb_mem_ctrl;

  logic        clk;
  logic        clear_n;
  logic [31:0] bus_in;
  logic        mar_in;
  logic        mdr_in;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [31:0] ram_rdata;
  logic [8:0]  mar_out;
  logic [31:0] mdr_out;
  logic        busy;
  logic        done;
  logic        ram_read;
  logic        ram_write;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;

  logic [31:0] ram_mem [512];

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int wr_base;
  int done_base;
  int n_done;
  int first_done;
  int gap_ok;
  int last_done;

  mem_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk),
    .clear_n(clear_n),
    .bus_in(bus_in),
    .mar_in(mar_in),
    .mdr_in(mdr_in),
    .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req),
    .ram_rdata(ram_rdata),
    .mar_out(mar_out),
    .mdr_out(mdr_out),
    .busy(busy),
    .done(done),
    .ram_read(ram_read),
    .ram_write(ram_write),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata <= ram_mem[ram_addr];
    if (ram_write) wr_cnt <= wr_cnt + 1;
    if (done)      done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic load_mar(input logic [31:0] v);
    bus_in = v; mar_in = 1'b1;
    @(negedge clk);
    mar_in = 1'b0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    bus_in = v; mdr_in = 1'b1;
    @(negedge clk);
    mdr_in = 1'b0;
  endtask

  task automatic do_write;
    mem_write_req = 1'b1;
    @(negedge clk);
    mem_write_req = 1'b0;
    cyc(2);
  endtask

  task automatic do_read;
    mem_read_req = 1'b1;
    @(negedge clk);
    mem_read_req = 1'b0;
    cyc(3);
  endtask

  initial begin
    clear_n = 1'b0; bus_in = '0; mar_in = 1'b0; mdr_in = 1'b0;
    mem_read_req = 1'b0; mem_write_req = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mar", {23'd0, mar_out}, 32'd0);
    chk("rst_mdr", mdr_out, 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);

    // Write 0xDEADBEEF to 0x005, step by step.
    load_mar(32'h0000_0005);
    load_mdr(32'hDEAD_BEEF);
    chk("ld_mar", {23'd0, mar_out}, 32'h005);
    chk("ld_mdr", mdr_out, 32'hDEAD_BEEF);
    mem_write_req = 1'b1;
    @(negedge clk);
    mem_write_req = 1'b0;
    chk("wr_k1_write", {31'd0, ram_write}, 32'd1);
    chk("wr_k1_done", {31'd0, done}, 32'd0);
    chk("wr_k1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("wr_k2_done", {31'd0, done}, 32'd1);
    chk("wr_k2_write", {31'd0, ram_write}, 32'd0);
    @(negedge clk);
    chk("wr_k3_busy", {31'd0, busy}, 32'd0);
    chk("wr_ram5", ram_mem[5], 32'hDEAD_BEEF);

    // Read it back after clearing MDR.
    load_mdr(32'h0);
    mem_read_req = 1'b1;
    @(negedge clk);
    mem_read_req = 1'b0;
    chk("rd_k1_read", {31'd0, ram_read}, 32'd1);
    chk("rd_k1_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("rd_k2_read", {31'd0, ram_read}, 32'd0);
    chk("rd_k2_done", {31'd0, done}, 32'd0);
    chk("rd_k2_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("rd_k3_done", {31'd0, done}, 32'd1);
    chk("rd_k3_mdr", mdr_out, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rd_k4_busy", {31'd0, busy}, 32'd0);

    // Address truncation: 0x305 -> 0x105.
    load_mar(32'h0000_0305);
    chk("trunc_mar", {23'd0, mar_out}, 32'h105);
    chk("trunc_addr", {23'd0, ram_addr}, 32'h105);
    load_mdr(32'h1234_5678);
    do_write();
    load_mdr(32'h0);
    do_read();
    chk("trunc_rd", mdr_out, 32'h1234_5678);
    chk("trunc_ram", ram_mem[9'h105], 32'h1234_5678);

    // Simultaneous requests: read wins, no write.
    load_mar(32'h0000_0010);
    load_mdr(32'h5555_5555);
    do_write();
    load_mdr(32'hAAAA_AAAA);
    wr_base = wr_cnt;
    mem_read_req = 1'b1; mem_write_req = 1'b1;
    @(negedge clk);
    mem_read_req = 1'b0; mem_write_req = 1'b0;
    chk("sim_read", {31'd0, ram_read}, 32'd1);
    cyc(4);
    chk("sim_nowr", wr_cnt - wr_base, 32'd0);
    chk("sim_mdr", mdr_out, 32'h5555_5555);
    chk("sim_ram", ram_mem[16], 32'h5555_5555);

    // Loads and requests ignored while busy.
    wr_base = wr_cnt; done_base = done_cnt;
    mem_read_req = 1'b1;
    @(negedge clk);
    mem_read_req = 1'b0;
    bus_in = 32'h0000_01FF; mar_in = 1'b1; mem_write_req = 1'b1;
    @(negedge clk);
    mar_in = 1'b0; mem_write_req = 1'b0;
    cyc(4);
    chk("busy_mar", {23'd0, mar_out}, 32'h010);
    chk("busy_nowr", wr_cnt - wr_base, 32'd0);
    chk("busy_1done", done_cnt - done_base, 32'd1);

    // Back-to-back reads with the request held for 12 edges.
    n_done = 0; first_done = -1; gap_ok = 1; last_done = -1;
    mem_read_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = i;
        if (last_done >= 0 && (i - last_done) != 4) gap_ok = 0;
        last_done = i;
      end
      if (i == 4) chk("b2b_idle4", {31'd0, busy}, 32'd0);
      if (i == 8) chk("b2b_idle8", {31'd0, busy}, 32'd0);
      if (i == 12) mem_read_req = 1'b0;
    end
    chk("b2b_ndone", n_done, 32'd3);
    chk("b2b_first", first_done, 32'd3);
    chk("b2b_gap", gap_ok, 32'd1);

    // Asynchronous reset during RD_CAP.
    mem_read_req = 1'b1;
    @(negedge clk);
    mem_read_req = 1'b0;
    @(negedge clk);
    chk("rstm_busy_pre", {31'd0, busy}, 32'd1);
    #2 clear_n = 1'b0;
    #1;
    chk("rstm_busy", {31'd0, busy}, 32'd0);
    chk("rstm_done", {31'd0, done}, 32'd0);
    chk("rstm_read", {31'd0, ram_read}, 32'd0);
    chk("rstm_write", {31'd0, ram_write}, 32'd0);
    chk("rstm_mar", {23'd0, mar_out}, 32'd0);
    chk("rstm_mdr", mdr_out, 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    cyc(2);
    chk("rstm_idle", {31'd0, busy}, 32'd0);
    chk("rstm_nodone", {31'd0, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access sequencer that sits directly upstream of the 512×32 synchronous RAM. It holds the Memory Address Register (MAR) and the Memory Data Register (MDR), and accepts single-word read and write requests from the control unit. It drives the RAM's read, write, address and data strobes over a fixed number of cycles, captures read data into the MDR, and signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `ADDR_W`, 9: RAM address width; MAR width.
- `DATA_W`, 32: data width; MDR and bus width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clear_n`  in  1  reset, asynchronous and active-low.
- `bus_in`  in  DATA_W  datapath bus; source for MAR and MDR loads.
- `mar_in`  in  1  load MAR from `bus_in[ADDR_W-1:0]`.
- `mdr_in`  in  1  load MDR from `bus_in`.
- `mem_read_req`  in  1  request a RAM read at MAR into MDR.
- `mem_write_req`  in  1  request a RAM write of MDR to MAR.
- `ram_rdata`  in  DATA_W  RAM `data_out`.
- `mar_out`  out  ADDR_W  current MAR.
- `mdr_out`  out  DATA_W  current MDR.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `ram_read`  out  1  RAM read strobe.
- `ram_write`  out  1  RAM write strobe.
- `ram_addr`  out  ADDR_W  RAM address; always equals MAR.
- `ram_wdata`  out  DATA_W  RAM write data; always equals MDR.

## Operation
- FSM states: IDLE, RD_REQ, RD_CAP, WR_REQ, DONE.
- Outputs are Moore-decoded from the state:
  - `ram_read` = RD_REQ.
  - `ram_write` = WR_REQ.
  - `done` = DONE.
  - `busy` = (state != IDLE).
- State transitions:
  - IDLE, `mem_read_req`=1 → RD_REQ.
  - IDLE, `mem_read_req`=0 and `mem_write_req`=1 → WR_REQ.
  - IDLE, no request → stay in IDLE.
  - RD_REQ → RD_CAP. The RAM samples the address at the edge ending RD_REQ.
  - RD_CAP → DONE. MDR ← `ram_rdata` at the edge ending RD_CAP.
  - WR_REQ → DONE. The RAM writes MDR at MAR at the edge ending WR_REQ.
  - DONE → IDLE unconditionally.
- Simultaneous read and write request in IDLE: the read wins. The write is dropped, not queued.
- Requests are sampled only in IDLE. Requests in any other state are ignored.
- A request held high continuously is re-accepted on each return to IDLE.
- `mar_in` and `mdr_in` take effect only in IDLE. While busy, MAR and MDR are frozen, except for the RD_CAP capture into MDR.
- `mar_in` together with a request in the same IDLE cycle: MAR loads first, and the access uses the new address.
- `mdr_in` together with `mem_write_req`: the write stores the new bus value.
- `mdr_in` together with `mem_read_req`: MDR loads the bus value, which the RAM data then overwrites in RD_CAP.
- MAR takes the low ADDR_W bits of `bus_in`; the upper bits are ignored. There is no address range check, and addresses wrap modulo 512.

## Timing
- On reset assertion (asynchronous, mid-operation included):
  - state → IDLE.
  - MAR = 0, MDR = 0.
  - `busy`, `done`, `ram_read` and `ram_write` = 0.
  - Any in-flight access is abandoned. A write is not performed unless its WR_REQ edge already occurred.
- The request is sampled at edge k. Counting cycles after that edge:
  - Read: RD_REQ at k+1, RD_CAP at k+2, DONE at k+3. `mdr_out` shows the new data from k+3 onward.
  - Write: WR_REQ at k+1, DONE at k+2. RAM contents are updated from edge k+2.
- Throughput: one read per 4 cycles, one write per 3 cycles.
- `done` is exactly one cycle wide and coincides with the final busy cycle.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state enum typedef (IDLE, RD_REQ, RD_CAP, WR_REQ, DONE);
  - default ADDR_W/DATA_W constants shared with the RAM instance.
- No sub-module. The FSM, MAR and MDR live in one module.
- The integration testbench instantiates `mem_ctrl` directly wired to the RAM.

## Test plan
- Reset mid-read: pull `clear_n` low during RD_CAP → all outputs 0, MAR=0, MDR=0 immediately; after release, state is IDLE.
- Write then read:
  - Load MAR=0x005 and MDR=0xDEADBEEF, pulse `mem_write_req` → `ram_write` high for one cycle, `done` at k+2.
  - Then load MDR=0, pulse `mem_read_req` → `done` at k+3, `mdr_out`=0xDEADBEEF.
- Address truncation:
  - `bus_in`=0x0000_0305 with `mar_in` → `mar_out`=0x105.
  - Write 0x12345678, then read at 0x105 → 0x12345678.
- Simultaneous requests: `mem_read_req`=`mem_write_req`=1 with MDR=0xAAAA_AAAA at address 0x010 holding 0x5555_5555 → a read occurs, `ram_write` never asserts, MDR=0x5555_5555.
- Ignored while busy: assert `mar_in` with `bus_in`=0x1FF and `mem_write_req` during RD_REQ → MAR unchanged, no write, exactly one `done`.
- Back-to-back: hold `mem_read_req` high for 12 cycles → `done` pulses exactly 3 times, 4 cycles apart; `busy` drops for one IDLE cycle between accesses.
